// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks every input combination of a small
// combinational unit, holds each for SETTLE cycles, samples the unit
// outputs and compares them against the EXPECTED truth table.
// It reports the mismatch count, the first failing index and pass/fail.
module truth_table_sequencer #(
   parameter int unsigned N_IN   = 3,
   parameter int unsigned N_OUT  = 3,
   parameter int unsigned SETTLE = 1,
   parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [N_IN-1:0]   dut_in,
   input  logic [N_OUT-1:0]  dut_out,
   output logic              sample_strobe,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     mismatch_count,
   output logic              fail_seen,
   output logic [N_IN-1:0]   first_fail_idx
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_APPLY,
      S_SAMPLE,
      S_DONE
   } state_t;

   // Settle counter is 4 bits wide: SETTLE is limited to 1..15.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

   state_t            r_state;
   logic [N_IN-1:0]   r_idx;
   logic [3:0]        r_settle;
   logic              r_strobe;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [N_IN:0]     r_cnt;
   logic              r_fail;
   logic [N_IN-1:0]   r_first;

   logic [N_OUT-1:0]  w_exp;
   logic              w_mismatch;
   logic [N_IN:0]     w_cnt_next;

   // Expected slice for the vector currently driven, and the compare result.
   always_comb begin
      w_exp      = EXPECTED[32'(r_idx) * N_OUT +: N_OUT];
      w_mismatch = (dut_out != w_exp);
      w_cnt_next = r_cnt + (N_IN+1)'(w_mismatch);
   end

   // Sweep state machine; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_settle <= '0;
         r_strobe <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
         r_cnt    <= '0;
         r_fail   <= 1'b0;
         r_first  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               // Without start, IDLE holds reset values and DONE holds results.
               if (start) begin
                  r_state  <= S_APPLY;
                  r_idx    <= '0;
                  r_settle <= SETTLE_LOAD;
                  r_strobe <= 1'b0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_pass   <= 1'b0;
                  r_cnt    <= '0;
                  r_fail   <= 1'b0;
                  r_first  <= '0;
               end
            end
            S_APPLY: begin
               if (r_settle == '0) begin
                  r_state  <= S_SAMPLE;
                  r_strobe <= 1'b1;
               end else begin
                  r_settle <= r_settle - 4'd1;
               end
            end
            S_SAMPLE: begin
               r_strobe <= 1'b0;
               if (w_mismatch) begin
                  r_cnt <= w_cnt_next;
                  if (!r_fail) begin
                     r_first <= r_idx;
                     r_fail  <= 1'b1;
                  end
               end
               if (r_idx == '1) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_cnt_next == '0);
               end else begin
                  r_state  <= S_APPLY;
                  r_idx    <= r_idx + N_IN'(1);
                  r_settle <= SETTLE_LOAD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dut_in         = r_idx;
   assign sample_strobe  = r_strobe;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign mismatch_count = r_cnt;
   assign fail_seen      = r_fail;
   assign first_fail_idx = r_first;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=1 and SETTLE=3)
// check a modelled unit f=a&b, g=a|c, h=b^c with an injectable fault mask.
// Expected strobes and sweep results are queued at start; a monitor pops them.
module tb_truth_table_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] dut_in   [2];
   logic [2:0] unit_out [2];
   logic       strobe   [2];
   logic       busy     [2];
   logic       done     [2];
   logic       pass     [2];
   logic [3:0] cnt      [2];
   logic       fail     [2];
   logic [2:0] first    [2];

   logic [2:0] mask [8];
   int         S [2] = '{1, 3};
   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   logic       done_q [2] = '{1'b0, 1'b0};

   typedef struct { int u; int idx; int cyc; } sexp_t;
   typedef struct { int u; int cnt; int first; int fail; int pass; int cyc; } rexp_t;
   sexp_t sq[$];
   rexp_t rq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference unit: the intended logic functions, optionally corrupted.
   function automatic logic [2:0] golden(input logic [2:0] v);
      logic a, b, c;
      a = v[2]; b = v[1]; c = v[0];
      return {a & b, a | c, b ^ c};
   endfunction

   assign unit_out[0] = golden(dut_in[0]) ^ mask[dut_in[0]];
   assign unit_out[1] = golden(dut_in[1]) ^ mask[dut_in[1]];

   truth_table_sequencer #(.N_IN(3), .N_OUT(3), .SETTLE(1), .EXPECTED(24'hDDA458)) u0 (
      .clk(clk), .reset(reset), .start(start), .dut_in(dut_in[0]), .dut_out(unit_out[0]),
      .sample_strobe(strobe[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .mismatch_count(cnt[0]), .fail_seen(fail[0]), .first_fail_idx(first[0]));

   truth_table_sequencer #(.N_IN(3), .N_OUT(3), .SETTLE(3), .EXPECTED(24'hDDA458)) u1 (
      .clk(clk), .reset(reset), .start(start), .dut_in(dut_in[1]), .dut_out(unit_out[1]),
      .sample_strobe(strobe[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .mismatch_count(cnt[1]), .fail_seen(fail[1]), .first_fail_idx(first[1]));

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops the expectation for each strobe and each rising done.
   always @(negedge clk) begin : monitor
      int k;
      for (int u = 0; u < 2; u++) begin
         if (strobe[u]) begin
            k = -1;
            foreach (sq[i]) if (k < 0 && sq[i].u == u) k = i;
            if (k < 0) chk($sformatf("u%0d unexpected_strobe", u), 1, 0);
            else begin
               chk($sformatf("u%0d strobe_dut_in", u), int'(dut_in[u]), sq[k].idx);
               chk($sformatf("u%0d strobe_cycle", u), cyc, sq[k].cyc);
               chk($sformatf("u%0d strobe_busy", u), int'(busy[u]), 1);
               sq.delete(k);
            end
         end
         if (done[u] && !done_q[u]) begin
            k = -1;
            foreach (rq[i]) if (k < 0 && rq[i].u == u) k = i;
            if (k < 0) chk($sformatf("u%0d unexpected_done", u), 1, 0);
            else begin
               chk($sformatf("u%0d mismatch_count", u), int'(cnt[u]), rq[k].cnt);
               chk($sformatf("u%0d first_fail_idx", u), int'(first[u]), rq[k].first);
               chk($sformatf("u%0d fail_seen", u), int'(fail[u]), rq[k].fail);
               chk($sformatf("u%0d pass", u), int'(pass[u]), rq[k].pass);
               chk($sformatf("u%0d done_cycle", u), cyc, rq[k].cyc);
               chk($sformatf("u%0d done_busy", u), int'(busy[u]), 0);
               rq.delete(k);
            end
         end
         done_q[u] = done[u];
      end
   end

   // Drive a start pulse and queue the expected strobes and results.
   task automatic kick();
      int c0, n, f;
      @(negedge clk);
      start = 1'b1;
      c0 = cyc + 1;
      n = 0; f = 0;
      for (int i = 7; i >= 0; i--) if (mask[i] != 3'b000) begin n++; f = i; end
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 8; i++) sq.push_back('{u, i, c0 + i*(S[u]+1) + S[u]});
         rq.push_back('{u, n, f, int'(n > 0), int'(n == 0), c0 + 8*(S[u]+1)});
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!(done[0] && done[1]) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("done_within_budget", int'(n < 200), 1);
      @(negedge clk);
   endtask

   task automatic sweep(input bit extra);
      kick();
      if (extra) begin
         repeat (4) @(negedge clk);
         start = 1'b1;
         @(negedge clk) start = 1'b0;
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk) start = 1'b0;
      end
      wait_done();
   endtask

   task automatic check_idle(input string nm);
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("%s u%0d dut_in", nm, u), int'(dut_in[u]), 0);
         chk($sformatf("%s u%0d busy", nm, u), int'(busy[u]), 0);
         chk($sformatf("%s u%0d done", nm, u), int'(done[u]), 0);
         chk($sformatf("%s u%0d pass", nm, u), int'(pass[u]), 0);
         chk($sformatf("%s u%0d count", nm, u), int'(cnt[u]), 0);
         chk($sformatf("%s u%0d fail_seen", nm, u), int'(fail[u]), 0);
         chk($sformatf("%s u%0d first", nm, u), int'(first[u]), 0);
         chk($sformatf("%s u%0d strobe", nm, u), int'(strobe[u]), 0);
      end
   endtask

   initial begin
      int n;
      foreach (mask[i]) mask[i] = 3'b000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_idle("reset");

      // Golden sweep, then results must be held in DONE.
      sweep(1'b0);
      repeat (5) @(negedge clk);
      chk("hold dut_in", int'(dut_in[0]), 7);
      chk("hold done", int'(done[0]), 1);
      chk("hold pass", int'(pass[0]), 1);

      // Single fault: h forced to 0 at index 5.
      mask[5] = 3'b001;
      sweep(1'b0);

      // Multiple faults: f inverted everywhere.
      foreach (mask[i]) mask[i] = 3'b100;
      sweep(1'b0);

      // Failing sweep with start pulses while busy, then a correct sweep from DONE.
      foreach (mask[i]) mask[i] = 3'b000;
      mask[2] = 3'b010;
      mask[6] = 3'b111;
      sweep(1'b1);
      foreach (mask[i]) mask[i] = 3'b000;
      sweep(1'b0);

      // Random fault patterns.
      for (int r = 0; r < 6; r++) begin
         foreach (mask[i]) mask[i] = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'b000;
         sweep(1'b0);
      end

      // Reset mid-sweep at dut_in=4.
      foreach (mask[i]) mask[i] = 3'b000;
      kick();
      n = 0;
      while (dut_in[0] != 3'd4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_idx4", int'(n < 100), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sq.delete();
      rq.delete();
      check_idle("midreset");
      repeat (20) @(negedge clk);
      check_idle("post_reset_idle");

      // Sweep after reset still works.
      mask[7] = 3'b110;
      sweep(1'b0);

      chk("queues_drained", sq.size() + rq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
